sync_fifo_flex: RTL and testbench
=================================

// Module: sync_fifo_flex
// PURPOSE
//  Parametrised single-clock FIFO; successor to the basic 16x8 synchronous FIFO.
//  Adds a selectable read mode (registered or first-word-fall-through), an occupancy count,
//  programmable almost-full/almost-empty flags and overflow/underflow error pulses.
//  Used as the general buffering element between streaming producer/consumer blocks.
// PARAMETERS
//  WIDTH      8   data width in bits (>=1)
//  DEPTH      16  entries; power of two, >=2
//  FWFT       0   0 = registered read (dout valid 1 cycle after rd), 1 = first-word-fall-through
//  AFULL_TH   12  almost_full asserts when count >= AFULL_TH; legal range 1..DEPTH
//  AEMPTY_TH  4   almost_empty asserts when count <= AEMPTY_TH; legal range 0..DEPTH-1
// PORTS
//  clk           in   1            clock, all logic on rising edge
//  rst           in   1            asynchronous, active-high reset
//  wr_en         in   1            write request
//  din           in   WIDTH        write data
//  full          out  1            count == DEPTH
//  almost_full   out  1            count >= AFULL_TH
//  overflow      out  1            1-cycle pulse: write rejected
//  rd_en         in   1            read request (pop)
//  dout          out  WIDTH        read data
//  empty         out  1            count == 0
//  almost_empty  out  1            count <= AEMPTY_TH
//  underflow     out  1            1-cycle pulse: read rejected
//  count         out  CW           occupancy 0..DEPTH, CW = $clog2(DEPTH)+1
// BEHAVIOUR
//  - Reset (async, immediate): wr_ptr=rd_ptr=0, count=0, empty=1, almost_empty=1, full=0,
//    almost_full=0, overflow=underflow=0, dout=0. Memory not cleared; never visible post-reset.
//  - Pointers ADDR_W+1 bits (ADDR_W=$clog2(DEPTH)); MSB is wrap bit, index wraps DEPTH-1 -> 0.
//  - Write accepted iff wr_en && !full; read accepted iff rd_en && !empty. Flags are sampled
//    pre-edge: a write into an empty FIFO cannot be read same cycle; a read from a full FIFO
//    does not free a slot for a same-cycle write.
//  - Both accepted same cycle: count unchanged, both pointers advance.
//  - count: +1 write only, -1 read only; all flags derive from registered count/pointers.
//  - overflow registered: high the cycle after an edge with wr_en && full. underflow likewise
//    for rd_en && empty. No state change on rejected requests.
//  - FWFT=0: dout registered; loads head word on accepted read, visible after that edge;
//    holds value otherwise (including while empty).
//  - FWFT=1: dout = head word combinationally whenever !empty, 0 when empty. Write to empty
//    FIFO: empty falls and data appears after that write edge (1-cycle latency). Accepted read
//    advances dout to next word after the edge.
//  - Reset mid-operation: all in-flight requests in the reset cycle are discarded.
// STRUCTURE
//  - Package sync_fifo_pkg: read-mode constants (FIFO_MODE_STD=0, FIFO_MODE_FWFT=1) and a
//    parameter-legality check function reused by other FIFOs.
//  - Sub-module fifo_mem_2p (#WIDTH, #DEPTH): reg array, synchronous write, async read port.
//  - Top: pointer/count logic, flag compare, error pulse regs, FWFT/STD output mux via generate.
//  - Elaboration error if DEPTH not power of two or thresholds out of range.
// TESTING (run in both FWFT=0 and FWFT=1, DEPTH=16, WIDTH=8)
//  1 Reset then write 0x01..0x10 -> full=1, count=16, almost_full from 12th write; 17th write
//    -> overflow pulse 1 cycle, count stays 16.
//  2 Read 16 -> data 0x01..0x10 in order (STD: 1 cycle after rd_en; FWFT: 0x01 on dout before
//    first rd_en); empty=1, count=0; extra rd_en -> underflow pulse, dout unchanged (STD)/0 (FWFT).
//  3 Fill 8, then 20 cycles simultaneous wr/rd -> count constant 8, order preserved across
//    pointer wrap (write index passes 15 -> 0).
//  4 Empty FIFO, wr_en and rd_en same cycle -> write accepted, underflow=1, count=1.
//  5 Full FIFO, wr_en and rd_en same cycle -> read accepted, overflow=1, count=15.
//  6 Fill 10, assert rst mid-cycle -> all outputs at reset values before next edge;
//    subsequent write 0xAA reads back 0xAA, no stale data.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared FIFO definitions: read-mode encodings and a parameter legality check
// that any FIFO variant can call at elaboration time.
package sync_fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic bit fifo_params_ok(input int depth, input int afull_th,
                                        input int aempty_th, input int mode);
    bit pow2;
    pow2 = (depth >= 2) && ((depth & (depth - 1)) == 0);
    return pow2 && (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1) &&
           ((mode == FIFO_MODE_STD) || (mode == FIFO_MODE_FWFT));
  endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: synchronous write, asynchronous read.
// Contents are never cleared; the FIFO pointers keep stale words unreachable.
module fifo_mem_2p #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_addr] <= wr_data;
  end

  assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Parametrised single-clock FIFO with registered or first-word-fall-through read,
// occupancy count, almost-full/almost-empty flags and overflow/underflow pulses.
module sync_fifo_flex
  import sync_fifo_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   almost_full,
  output logic                   overflow,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   almost_empty,
  output logic                   underflow,
  output logic [$clog2(DEPTH):0] count
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CW     = ADDR_W + 1;

  if (!fifo_params_ok(DEPTH, AFULL_TH, AEMPTY_TH, FWFT)) begin : g_bad_params
    $error("sync_fifo_flex: illegal DEPTH/threshold/mode parameters");
  end

  logic [ADDR_W:0]   wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic              overflow_reg, underflow_reg;
  logic              wr_ok, rd_ok;
  logic [WIDTH-1:0]  head_data;

  // Full/empty come from the pointers (wrap bit distinguishes the two equal-index cases);
  // both depend only on state registered before the edge.
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                 (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
  assign almost_full  = (count_reg >= CW'(AFULL_TH));
  assign almost_empty = (count_reg <= CW'(AEMPTY_TH));
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    count_next = count_reg;
    case ({wr_ok, rd_ok})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (rd_ok) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg     <= count_next;
      overflow_reg  <= wr_en && full;
      underflow_reg <= rd_en && empty;
    end
  end

  fifo_mem_2p #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_ok),
    .wr_addr (wr_ptr_reg[ADDR_W-1:0]),
    .wr_data (din),
    .rd_addr (rd_ptr_reg[ADDR_W-1:0]),
    .rd_data (head_data)
  );

  if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
    assign dout = empty ? '0 : head_data;
  end else begin : g_std
    logic [WIDTH-1:0] dout_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        dout_reg <= '0;
      else if (rd_ok) dout_reg <= head_data;
    end
    assign dout = dout_reg;
  end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Directed bench driving a registered-read and an FWFT instance with identical stimulus.
module tb_sync_fifo_flex;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic [7:0] din = 8'h00;

  logic       full_s, afull_s, ovf_s, empty_s, aempty_s, unf_s;
  logic [7:0] dout_s;
  logic [4:0] count_s;
  logic       full_f, afull_f, ovf_f, empty_f, aempty_f, unf_f;
  logic [7:0] dout_f;
  logic [4:0] count_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(0), .AFULL_TH(12), .AEMPTY_TH(4)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full_s), .almost_full(afull_s),
    .overflow(ovf_s), .rd_en(rd_en), .dout(dout_s), .empty(empty_s),
    .almost_empty(aempty_s), .underflow(unf_s), .count(count_s)
  );

  sync_fifo_flex #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AFULL_TH(12), .AEMPTY_TH(4)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .full(full_f), .almost_full(afull_f),
    .overflow(ovf_f), .rd_en(rd_en), .dout(dout_f), .empty(empty_f),
    .almost_empty(aempty_f), .underflow(unf_f), .count(count_f)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    logic [17:0] got_s, got_f, exp;
    exp   = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 7'd0};
    got_s = {full_s, afull_s, ovf_s, empty_s, aempty_s, unf_s, count_s, dout_s[6:0]};
    got_f = {full_f, afull_f, ovf_f, empty_f, aempty_f, unf_f, count_f, dout_f[6:0]};
    checks++;
    if (got_s !== exp || dout_s[7] !== 1'b0) begin
      errors++;
      $display("FAIL %s std flags/count/dout got=%h dout=%h expected=%h dout=00", tag, got_s, dout_s, exp);
    end
    checks++;
    if (got_f !== exp || dout_f[7] !== 1'b0) begin
      errors++;
      $display("FAIL %s fwft flags/count/dout got=%h dout=%h expected=%h dout=00", tag, got_f, dout_f, exp);
    end
    $display("reset check %s: std count=%0d fwft count=%0d", tag, count_s, count_f);
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    check_reset_values("reset");
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 16; i++) begin
      wr_en = 1'b1; din = 8'(i);
      tick();
      checks++;
      if (count_s !== 5'(i) || count_f !== 5'(i)) begin
        errors++; $display("FAIL fill_count[%0d] got std=%0d fwft=%0d expected=%0d", i, count_s, count_f, i);
      end
      checks++;
      if (afull_s !== (i >= 12) || afull_f !== (i >= 12) || full_s !== (i == 16) || full_f !== (i == 16)) begin
        errors++; $display("FAIL fill_flags[%0d] got afull=%b/%b full=%b/%b expected afull=%b full=%b",
                           i, afull_s, afull_f, full_s, full_f, i >= 12, i == 16);
      end
      checks++;
      if (dout_f !== 8'h01 || empty_f !== 1'b0) begin
        errors++; $display("FAIL fill_fwft_head[%0d] got dout=%h empty=%b expected dout=01 empty=0", i, dout_f, empty_f);
      end
      $display("write %h: count std=%0d fwft=%0d", din, count_s, count_f);
    end
    wr_en = 1'b1; din = 8'h11;
    tick();
    checks++;
    if (ovf_s !== 1'b1 || ovf_f !== 1'b1 || count_s !== 5'd16 || count_f !== 5'd16) begin
      errors++; $display("FAIL overflow_pulse got ovf=%b/%b count=%0d/%0d expected ovf=1 count=16", ovf_s, ovf_f, count_s, count_f);
    end
    $display("write 11 into full: overflow std=%b fwft=%b", ovf_s, ovf_f);
    wr_en = 1'b0;
    tick();
    checks++;
    if (ovf_s !== 1'b0 || ovf_f !== 1'b0) begin
      errors++; $display("FAIL overflow_clear got ovf=%b/%b expected 0", ovf_s, ovf_f);
    end
  endtask

  task automatic test_drain();
    logic [7:0] exp_f;
    for (int i = 1; i <= 16; i++) begin
      rd_en = 1'b1;
      tick();
      exp_f = (i < 16) ? 8'(i + 1) : 8'h00;
      checks++;
      if (dout_s !== 8'(i) || dout_f !== exp_f) begin
        errors++; $display("FAIL drain_data[%0d] got std=%h fwft=%h expected std=%h fwft=%h", i, dout_s, dout_f, 8'(i), exp_f);
      end
      checks++;
      if (count_s !== 5'(16 - i) || count_f !== 5'(16 - i) || aempty_s !== (16 - i <= 4) || aempty_f !== (16 - i <= 4)) begin
        errors++; $display("FAIL drain_count[%0d] got count=%0d/%0d aempty=%b/%b expected count=%0d aempty=%b",
                           i, count_s, count_f, aempty_s, aempty_f, 16 - i, 16 - i <= 4);
      end
      $display("read: std dout=%h fwft dout=%h count=%0d", dout_s, dout_f, count_s);
    end
    checks++;
    if (empty_s !== 1'b1 || empty_f !== 1'b1) begin
      errors++; $display("FAIL drain_empty got %b/%b expected 1", empty_s, empty_f);
    end
    rd_en = 1'b1;
    tick();
    checks++;
    if (unf_s !== 1'b1 || unf_f !== 1'b1 || dout_s !== 8'h10 || dout_f !== 8'h00 || count_s !== 5'd0) begin
      errors++; $display("FAIL underflow_pulse got unf=%b/%b dout=%h/%h count=%0d expected unf=1 dout=10/00 count=0",
                         unf_s, unf_f, dout_s, dout_f, count_s);
    end
    $display("read from empty: underflow std=%b fwft=%b", unf_s, unf_f);
    rd_en = 1'b0;
    tick();
    checks++;
    if (unf_s !== 1'b0 || unf_f !== 1'b0) begin
      errors++; $display("FAIL underflow_clear got %b/%b expected 0", unf_s, unf_f);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 8; k++) begin
      wr_en = 1'b1; din = 8'(8'h20 + k);
      tick();
    end
    for (int j = 0; j < 20; j++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 8'(8'h28 + j);
      tick();
      checks++;
      if (count_s !== 5'd8 || count_f !== 5'd8 || dout_s !== 8'(8'h20 + j) || dout_f !== 8'(8'h21 + j)) begin
        errors++; $display("FAIL b2b[%0d] got count=%0d/%0d dout=%h/%h expected count=8 dout=%h/%h",
                           j, count_s, count_f, dout_s, dout_f, 8'(8'h20 + j), 8'(8'h21 + j));
      end
      $display("wr+rd %h: std dout=%h fwft dout=%h count=%0d", din, dout_s, dout_f, count_s);
    end
    wr_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dout_f !== 8'(8'h34 + k)) begin
        errors++; $display("FAIL b2b_drain_fwft[%0d] got %h expected %h", k, dout_f, 8'(8'h34 + k));
      end
      rd_en = 1'b1;
      tick();
      checks++;
      if (dout_s !== 8'(8'h34 + k)) begin
        errors++; $display("FAIL b2b_drain_std[%0d] got %h expected %h", k, dout_s, 8'(8'h34 + k));
      end
    end
    rd_en = 1'b0;
    checks++;
    if (count_s !== 5'd0 || count_f !== 5'd0 || empty_s !== 1'b1) begin
      errors++; $display("FAIL b2b_final got count=%0d/%0d empty=%b expected 0/0/1", count_s, count_f, empty_s);
    end
  endtask

  task automatic test_empty_wr_rd();
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h55;
    tick();
    checks++;
    if (count_s !== 5'd1 || count_f !== 5'd1 || unf_s !== 1'b1 || unf_f !== 1'b1) begin
      errors++; $display("FAIL empty_wr_rd got count=%0d/%0d unf=%b/%b expected count=1 unf=1", count_s, count_f, unf_s, unf_f);
    end
    checks++;
    if (dout_s !== 8'h3b || dout_f !== 8'h55) begin
      errors++; $display("FAIL empty_wr_rd_dout got %h/%h expected 3b/55", dout_s, dout_f);
    end
    $display("wr+rd on empty: count=%0d underflow=%b", count_s, unf_s);
    wr_en = 1'b0; rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout_s !== 8'h55 || count_s !== 5'd0 || unf_s !== 1'b0 || dout_f !== 8'h00) begin
      errors++; $display("FAIL empty_wr_rd_pop got dout=%h/%h count=%0d unf=%b expected 55/00 0 0", dout_s, dout_f, count_s, unf_s);
    end
  endtask

  task automatic test_full_wr_rd();
    for (int i = 0; i < 16; i++) begin
      wr_en = 1'b1; din = 8'(8'h60 + i);
      tick();
    end
    wr_en = 1'b1; rd_en = 1'b1; din = 8'h99;
    tick();
    checks++;
    if (count_s !== 5'd15 || count_f !== 5'd15 || ovf_s !== 1'b1 || ovf_f !== 1'b1) begin
      errors++; $display("FAIL full_wr_rd got count=%0d/%0d ovf=%b/%b expected count=15 ovf=1", count_s, count_f, ovf_s, ovf_f);
    end
    checks++;
    if (dout_s !== 8'h60 || dout_f !== 8'h61 || full_s !== 1'b0) begin
      errors++; $display("FAIL full_wr_rd_dout got %h/%h full=%b expected 60/61 full=0", dout_s, dout_f, full_s);
    end
    $display("wr+rd on full: count=%0d overflow=%b", count_s, ovf_s);
    wr_en = 1'b0; rd_en = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; din = 8'(8'h70 + i);
      tick();
    end
    checks++;
    if (count_s !== 5'd10 || count_f !== 5'd10) begin
      errors++; $display("FAIL pre_reset_count got %0d/%0d expected 10", count_s, count_f);
    end
    din = 8'hEE; rd_en = 1'b1;
    #3 rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    tick();
    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    tick();
    checks++;
    if (count_s !== 5'd0 || count_f !== 5'd0 || empty_f !== 1'b1) begin
      errors++; $display("FAIL post_reset_count got %0d/%0d empty=%b expected 0 empty=1", count_s, count_f, empty_f);
    end
    wr_en = 1'b1; din = 8'hAA;
    tick();
    wr_en = 1'b0;
    checks++;
    if (dout_f !== 8'hAA || count_s !== 5'd1) begin
      errors++; $display("FAIL post_reset_write got fwft=%h count=%0d expected aa 1", dout_f, count_s);
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    checks++;
    if (dout_s !== 8'hAA || count_s !== 5'd0 || empty_s !== 1'b1) begin
      errors++; $display("FAIL post_reset_read got std=%h count=%0d empty=%b expected aa 0 1", dout_s, count_s, empty_s);
    end
    $display("write/read aa after reset: std dout=%h", dout_s);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_back_to_back();
    test_empty_wr_rd();
    test_full_wr_rd();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
